csa_resolve_accum: RTL and testbench
====================================

CSA_RESOLVE_ACCUM -- requirements
Module: csa_resolve_accum

Interface
REQ-001 SHALL have parameter BITS, default 32: coefficient data width.
REQ-002 SHALL have parameter CGES, default 49: number of coefficients summed by the upstream adder tree.
REQ-003 SHALL have parameter MAX, default $clog2(CGES)+BITS: vs/vc width.
REQ-004 SHALL have parameter ACC_LEN, default 4, legal range >=1: tree outputs summed per frame.
REQ-005 SHALL have parameter OUT_W, default MAX+$clog2(ACC_LEN)+1: result width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  pipeline enable.
REQ-009 clear  input  1  synchronous flush of the pipeline and the frame state.
REQ-010 vs  input  MAX  carry-save sum word from the adder tree.
REQ-011 vc  input  MAX  carry-save carry word from the adder tree.
REQ-012 in_valid  input  1  vs/vc pair valid.
REQ-013 in_ready  output  1  block accepts the pair this cycle.
REQ-014 result  output  OUT_W  accumulated frame sum.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts result.

Function
REQ-017 SHALL define adv = en & (~out_valid | out_ready) & ~clear; in_ready SHALL equal adv combinationally.
REQ-018 An input transfer SHALL occur iff in_valid & in_ready at a rising edge.
REQ-019 Stage 1 SHALL register lo = vs[H-1:0]+vc[H-1:0] with H = MAX/2 (floor), the carry out of bit H-1, vs[MAX-1:H], vc[MAX-1:H], and a valid bit.
REQ-020 Stage 2 SHALL register sum = {vs_hi+vc_hi+carry, lo} truncated to MAX bits, with a valid bit; the carry out of bit MAX-1 SHALL be discarded (mod 2^MAX).
REQ-021 All stage registers, their valid bits, the counter and the accumulator SHALL update only on edges where adv=1; valid bits SHALL shift in as 0 when no transfer occurs.
REQ-022 On an adv edge with stage-2 valid, the block SHALL add sum, zero-extended to OUT_W, to acc and increment cnt (range 0..ACC_LEN-1).
REQ-023 When cnt=ACC_LEN-1 on that edge, the block SHALL load result with acc+sum, set out_valid, clear acc to 0 and wrap cnt to 0.
REQ-024 Latency SHALL be fixed: the frame whose last element transfers at edge k SHALL show out_valid=1 after edge k+2.
REQ-025 out_valid SHALL clear on an edge with out_ready=1 unless a new result loads on the same edge, in which case out_valid SHALL stay 1 with the new data.
REQ-026 Output draining SHALL be independent of en.
REQ-027 While out_valid=1 and out_ready=0, result SHALL be stable and in_ready SHALL be 0; no data SHALL be lost or reordered.
REQ-028 With en=0, no pipeline, counter or accumulator state SHALL change.
REQ-029 clear=1 SHALL take priority over all other events and, at the edge, zero the stage valids, cnt, acc, out_valid and result.
REQ-030 With ACC_LEN=1, every transfer SHALL produce one result.

Reset
REQ-031 reset_n=0 SHALL immediately zero every register: result=0, out_valid=0, cnt=0, acc=0, and all stage data and valids.
REQ-032 in_ready SHALL follow REQ-017 during reset, i.e. equal en & ~clear.
REQ-033 A reset asserted mid-frame SHALL discard all in-flight data; the first post-reset transfer SHALL start a new frame.

Verification (MAX=38, H=19, ACC_LEN=4, OUT_W=41)
REQ-034 Reset then en=1, in_valid=0 -> result=0, out_valid=0, in_ready=1.
REQ-035 Four back-to-back transfers (10,5), (1,2), (0,0), (100,200), last at edge k -> out_valid after k+2, result=318.
REQ-036 vs=2^19-1, vc=1 -> stage-2 sum=2^19 (H-boundary carry); frame of four (2^38-1, 1) pairs -> result=0 (MAX wrap).
REQ-037 Hold out_ready=0 with one result pending and a second frame fed -> in_ready=0, first result stable; then out_ready=1 -> both results delivered in order, none lost.
REQ-038 clear after 2 of 4 elements, then 4 pairs (1,1) -> result=8.
REQ-039 reset_n pulse mid-frame with out_valid=1 -> out_valid=0 at once; next full frame gives its exact sum.

Source files
------------

// File: rtl/csa_resolve_accum.sv
// Resolves a carry-save (vs, vc) pair in two half-width stages and sums ACC_LEN
// resolved words into one frame result, with a valid/ready handshake on both ends.
module csa_resolve_accum #(
   parameter int unsigned BITS    = 32,
   parameter int unsigned CGES    = 49,
   parameter int unsigned MAX     = $clog2(CGES) + BITS,
   parameter int unsigned ACC_LEN = 4,
   parameter int unsigned OUT_W   = MAX + $clog2(ACC_LEN) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clear,
   input  logic [MAX-1:0]   vs,
   input  logic [MAX-1:0]   vc,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] result,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned H  = MAX / 2;
   localparam int unsigned HW = MAX - H;
   localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CW-1:0] CntLast = CW'(ACC_LEN - 1);

   logic             adv;
   logic             frame_done;
   logic [H:0]       lo_full;
   logic [HW-1:0]    hi_sum;
   logic [OUT_W-1:0] acc_next;

   logic [H-1:0]     s1_lo;
   logic             s1_c;
   logic [HW-1:0]    s1_vs_hi;
   logic [HW-1:0]    s1_vc_hi;
   logic             s1_v;
   logic [MAX-1:0]   s2_sum;
   logic             s2_v;
   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] acc;

   // The whole pipeline moves in lockstep; a held result stalls everything upstream.
   always_comb begin
      adv        = en & (~out_valid | out_ready) & ~clear;
      in_ready   = adv;
      lo_full    = {1'b0, vs[H-1:0]} + {1'b0, vc[H-1:0]};
      hi_sum     = s1_vs_hi + s1_vc_hi + HW'(s1_c);
      acc_next   = acc + {{(OUT_W - MAX){1'b0}}, s2_sum};
      frame_done = adv & s2_v & (cnt == CntLast);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_lo    <= '0;
         s1_c     <= 1'b0;
         s1_vs_hi <= '0;
         s1_vc_hi <= '0;
         s1_v     <= 1'b0;
         s2_sum   <= '0;
         s2_v     <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
      end else if (clear) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
      end else if (adv) begin
         s1_lo    <= lo_full[H-1:0];
         s1_c     <= lo_full[H];
         s1_vs_hi <= vs[MAX-1:H];
         s1_vc_hi <= vc[MAX-1:H];
         s1_v     <= in_valid;
         s2_sum   <= {hi_sum, s1_lo};
         s2_v     <= s1_v;
         if (s2_v) begin
            if (cnt == CntLast) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   // Draining depends only on out_ready, so a result can leave while en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else if (frame_done) begin
         result    <= acc_next;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csa_resolve_accum.sv
// Self-checking bench for csa_resolve_accum: directed scenarios plus a randomized
// run scored against a frame-sum reference model.
module tb_csa_resolve_accum;

   localparam int MAX     = 38;
   localparam int ACC_LEN = 4;
   localparam int OUT_W   = 41;

   logic             clk = 1'b0;
   logic             reset_n, en, clear, in_valid, out_ready;
   logic [MAX-1:0]   vs, vc;
   logic             in_ready, out_valid;
   logic [OUT_W-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   csa_resolve_accum dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .clear     (clear),
      .vs        (vs),
      .vc        (vc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Value the adder tree meant: vs + vc modulo 2^MAX.
   function automatic logic [63:0] pair_sum(input logic [63:0] a, input logic [63:0] b);
      return (a + b) & ((64'd1 << MAX) - 64'd1);
   endfunction

   function automatic logic [MAX-1:0] rnd();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[MAX-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [MAX-1:0] a, input logic [MAX-1:0] b);
      bit ok;
      ok = 0;
      vs = a;
      vc = b;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
      end
   endtask

   task automatic get_result(output logic [OUT_W-1:0] r);
      bit ok;
      ok = 0;
      r = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (out_valid) begin
            r  = result;
            ok = 1;
         end else begin
            step();
         end
      end
      if (ok) step();
      else begin
         n_checks++;
         n_fail++;
         $display("FAIL result_timeout: out_valid stayed 0, required 1 within 50 cycles");
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; en = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      vs = '0; vc = '0;
      #2;
      n_checks++;
      if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: got result=%0d out_valid=%b in_ready=%b, required 0 0 1",
                  result, out_valid, in_ready);
      end
      en = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready_en0: got %b, required 0", in_ready);
      end
      en = 1'b1; clear = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready_clear: got %b, required 0", in_ready);
      end
      clear = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      step();
      n_checks++;
      if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: got result=%0d out_valid=%b in_ready=%b, required 0 0 1",
                  result, out_valid, in_ready);
      end
   endtask

   task automatic test_basic_latency();
      send(38'd10, 38'd5);
      send(38'd1, 38'd2);
      send(38'd0, 38'd0);
      send(38'd100, 38'd200);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_k: out_valid=%b after last edge, required 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_k1: out_valid=%b after edge k+1, required 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || result !== 41'd318) begin
         n_fail++;
         $display("FAIL latency_k2: got out_valid=%b result=%0d, required 1 318",
                  out_valid, result);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: out_valid=%b after accept, required 0", out_valid);
      end
   endtask

   task automatic test_boundary();
      logic [OUT_W-1:0] r;
      logic [MAX-1:0]   lo_ones, all_ones;
      lo_ones  = MAX'((64'd1 << 19) - 64'd1);
      all_ones = MAX'((64'd1 << MAX) - 64'd1);
      send(lo_ones, 38'd1);
      step();
      n_checks++;
      if (dut.s2_sum !== MAX'(64'd1 << 19)) begin
         n_fail++;
         $display("FAIL h_carry: stage-2 sum=%0h, required %0h", dut.s2_sum, 64'd1 << 19);
      end
      for (int i = 0; i < 3; i++) send(lo_ones, 38'd1);
      get_result(r);
      n_checks++;
      if (r !== OUT_W'(64'd1 << 21)) begin
         n_fail++;
         $display("FAIL h_carry_frame: result=%0d, required %0d", r, 64'd1 << 21);
      end
      for (int i = 0; i < 4; i++) send(all_ones, 38'd1);
      get_result(r);
      n_checks++;
      if (r !== '0) begin
         n_fail++;
         $display("FAIL max_wrap: result=%0d, required 0", r);
      end
   endtask

   task automatic test_backpressure();
      logic [MAX-1:0]   a [8];
      logic [MAX-1:0]   b [8];
      logic [63:0]      exp_a, exp_b;
      logic [OUT_W-1:0] r;
      exp_a = 0;
      exp_b = 0;
      for (int i = 0; i < 8; i++) begin
         a[i] = rnd();
         b[i] = rnd();
         if (i < 4) exp_a += pair_sum(64'(a[i]), 64'(b[i]));
         else       exp_b += pair_sum(64'(a[i]), 64'(b[i]));
      end
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(a[i], b[i]);
      vs = a[6]; vc = b[6]; in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== OUT_W'(exp_a)) begin
            n_fail++;
            $display("FAIL hold_%0d: got in_ready=%b out_valid=%b result=%0d, required 0 1 %0d",
                     c, in_ready, out_valid, result, exp_a);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_in_ready: got %b, required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL first_consumed: out_valid=%b, required 0", out_valid);
      end
      send(a[7], b[7]);
      get_result(r);
      n_checks++;
      if (r !== OUT_W'(exp_b)) begin
         n_fail++;
         $display("FAIL second_result: result=%0d, required %0d", r, exp_b);
      end
   endtask

   task automatic test_clear();
      logic [OUT_W-1:0] r;
      out_ready = 1'b1;
      send(rnd(), rnd());
      send(rnd(), rnd());
      clear = 1'b1; in_valid = 1'b1; vs = rnd(); vc = rnd();
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_in_ready: got %b, required 0", in_ready);
      end
      step();
      clear = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) send(38'd1, 38'd1);
      get_result(r);
      n_checks++;
      if (r !== 41'd8) begin
         n_fail++;
         $display("FAIL clear_frame: result=%0d, required 8", r);
      end
   endtask

   task automatic test_reset_mid();
      logic [MAX-1:0]   a [4];
      logic [MAX-1:0]   b [4];
      logic [63:0]      e;
      logic [OUT_W-1:0] r;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(rnd(), rnd());
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_valid: out_valid=%b, required 1", out_valid);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || result !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got out_valid=%b result=%0d, required 0 0", out_valid, result);
      end
      step();
      reset_n = 1'b1; out_ready = 1'b1;
      e = 0;
      for (int i = 0; i < 4; i++) begin
         a[i] = rnd();
         b[i] = rnd();
         e += pair_sum(64'(a[i]), 64'(b[i]));
      end
      for (int i = 0; i < 4; i++) send(a[i], b[i]);
      get_result(r);
      n_checks++;
      if (r !== OUT_W'(e)) begin
         n_fail++;
         $display("FAIL post_reset_frame: result=%0d, required %0d", r, e);
      end
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] exp_q[$];
      logic [63:0]      run;
      logic [OUT_W-1:0] e;
      int               cnt, sent;
      run = 0; cnt = 0; sent = 0;
      for (int cyc = 0; cyc < 3000 && (sent < 48 || exp_q.size() > 0); cyc++) begin
         en        = ($urandom() % 8) != 0;
         out_ready = ($urandom() % 3) != 0;
         in_valid  = (sent < 48) && (($urandom() % 4) != 0);
         vs        = rnd();
         vc        = rnd();
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra: unexpected result=%0d, required none", result);
            end else begin
               e = exp_q.pop_front();
               if (result !== e) begin
                  n_fail++;
                  $display("FAIL rand_result: result=%0d, required %0d", result, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            run += pair_sum(64'(vs), 64'(vc));
            cnt++;
            sent++;
            if (cnt == ACC_LEN) begin
               exp_q.push_back(OUT_W'(run));
               run = 0;
               cnt = 0;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
      n_checks++;
      if (exp_q.size() != 0 || sent != 48) begin
         n_fail++;
         $display("FAIL rand_complete: pending=%0d sent=%0d, required 0 48", exp_q.size(), sent);
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_boundary();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
